regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Owns the single write port of the pipeline register file and shares it between two requesters:
  - the pipeline writeback stage (primary, cannot be stalled);
  - an auxiliary source for late load returns and debug writes (secondary, valid/ready).
- After reset, walks and clears registers 1..2^REG_SEL_BITS-1, since the register file itself resets only r0.
- Exposes a pending-write lookup so the hazard unit can stall reads of registers with writes still in flight.

Parameters:
REG_DATA_WIDTH, 32, data width of one register
REG_SEL_BITS, 5, register select width; 2^REG_SEL_BITS registers
AUX_DEPTH, 2, auxiliary FIFO entries; power of two, >=2

Ports:
clock  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-low; 0 sampled at posedge resets the block
wb_valid  input  1  writeback request this cycle; no ready, always accepted in RUN
wb_sel  input  REG_SEL_BITS  writeback destination register
wb_data  input  REG_DATA_WIDTH  writeback data
aux_valid  input  1  auxiliary write request
aux_ready  output  1  auxiliary request accepted when aux_valid & aux_ready
aux_sel  input  REG_SEL_BITS  auxiliary destination register
aux_data  input  REG_DATA_WIDTH  auxiliary data
rf_wEn  output  1  register file write enable (registered)
rf_write_sel  output  REG_SEL_BITS  register file write select (registered)
rf_write_data  output  REG_DATA_WIDTH  register file write data (registered)
chk_sel  input  REG_SEL_BITS  register queried by hazard logic
chk_pending  output  1  write to chk_sel queued or being written
init_done  output  1  clear sequence finished; pipeline must hold until 1
aux_count  output  clog2(AUX_DEPTH)+1  current auxiliary FIFO occupancy

Behaviour:
- Reset (reset==0 at posedge):
  - state<=INIT, init_ptr<=1, FIFO flushed, aux_count 0.
  - rf_wEn, rf_write_sel, rf_write_data, init_done all 0.
  - Reset mid-operation discards queued aux entries and any pending output write; INIT restarts.
- States: INIT, RUN.
- INIT:
  - Each cycle registers a write of 0 to init_ptr, then increments init_ptr.
  - After issuing register 2^REG_SEL_BITS-1, moves to RUN: 31 write cycles at default.
  - wb_valid and aux_valid are ignored; aux_ready=0; init_done=0.
- RUN:
  - init_done=1 and stays 1 until reset.
  - aux_ready = (aux_count < AUX_DEPTH), taken from the registered count. A pop in the same cycle does not raise aux_ready.
- Port selection each RUN cycle, registered, so the write appears on rf_* the next cycle:
  1. wb_valid & wb_sel!=0: write wb_sel/wb_data.
  2. Else FIFO non-empty: pop head, write its sel/data.
  3. Else rf_wEn<=0; rf_write_sel/rf_write_data hold their previous values.
- Zero-register handling:
  - wb_valid with wb_sel==0 is a no-request and does not block a FIFO drain.
  - An aux request with aux_sel==0 is handshaken (accepted) but not enqueued.
- FIFO:
  - Strict in-order drain; circular pointers wrap modulo AUX_DEPTH.
  - Push and pop in the same cycle are legal; aux_count is unchanged.
  - Writeback has absolute priority, so aux may wait indefinitely while wb_valid streams. This is by design; the hazard unit uses chk_pending.
- chk_pending (combinational) is 1 when chk_sel!=0 and either:
  - any valid FIFO entry has sel==chk_sel; or
  - rf_wEn==1 and rf_write_sel==chk_sel, since the register file still returns the old value that cycle.
- An aux entry pushed this cycle is not yet visible to chk_pending; it becomes visible the next cycle.
- Duplicate sels in the FIFO are allowed; the later entry wins by order.

Test Plan:
1. Hold reset=0 for 2 cycles, then release -> rf_wEn=1 for 31 consecutive cycles with rf_write_sel=1..31 and rf_write_data=0; init_done=1 the cycle after sel 31 is issued; rf_wEn=0 afterwards with no requests.
2. In RUN, wb_valid=1, wb_sel=5, wb_data=0xDEADBEEF for one cycle -> next cycle rf_wEn=1, rf_write_sel=5, rf_write_data=0xDEADBEEF; chk_sel=5 gives chk_pending=1 that cycle and 0 the cycle after.
3. wb_valid held with sel=3; push aux (7,0x11) then (9,0x22) -> aux_count=2, aux_ready=0, chk_pending=1 for sel 7 and 9; a third aux request is stalled. Drop wb_valid -> writes sel7=0x11 then sel9=0x22 on consecutive cycles, then the third is accepted.
4. Empty FIFO; same cycle wb (4,0xA) and aux (4,0xB) -> rf writes sel4=0xA, then next cycle sel4=0xB; the final value is 0xB.
5. wb_valid with wb_sel=0 plus aux_sel=0 -> aux handshake completes, aux_count stays 0, no rf_wEn. wb_sel=0 with a queued aux entry -> the entry drains that cycle.
6. FIFO holding 2 entries, assert reset=0 for one cycle -> aux_count=0, init_done=0, aux_ready=0; full 31-cycle INIT repeats; the flushed entries are never written.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Purpose: arbitrates the register-file write port between writeback and an auxiliary FIFO, and clears r1..rN after reset.
// Latency: one cycle from an accepted request (or a FIFO head pop) to the registered rf_* write.
// Backpressure: writeback is never stalled; aux is valid/ready, with ready dropping while the FIFO is full.
//
// Ports:
//   clock, reset          - single clock; synchronous active-low reset
//   wb_valid/sel/data     - primary writeback request, always taken in RUN
//   aux_valid/ready/sel/data - secondary request queued in an AUX_DEPTH-entry FIFO
//   rf_wEn/write_sel/write_data - registered register-file write port
//   chk_sel/chk_pending   - hazard lookup: write to chk_sel queued or currently on rf_*
//   init_done             - high once the post-reset clear sweep is finished
//   aux_count             - current FIFO occupancy
module regfile_write_scheduler #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5,
    parameter int AUX_DEPTH      = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wb_valid,
    input  logic [REG_SEL_BITS-1:0]     wb_sel,
    input  logic [REG_DATA_WIDTH-1:0]   wb_data,
    input  logic                        aux_valid,
    output logic                        aux_ready,
    input  logic [REG_SEL_BITS-1:0]     aux_sel,
    input  logic [REG_DATA_WIDTH-1:0]   aux_data,
    output logic                        rf_wEn,
    output logic [REG_SEL_BITS-1:0]     rf_write_sel,
    output logic [REG_DATA_WIDTH-1:0]   rf_write_data,
    input  logic [REG_SEL_BITS-1:0]     chk_sel,
    output logic                        chk_pending,
    output logic                        init_done,
    output logic [$clog2(AUX_DEPTH):0]  aux_count
);

    localparam int PW = $clog2(AUX_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                    state_q;
    logic [REG_SEL_BITS-1:0]   init_ptr_q;
    logic [REG_SEL_BITS-1:0]   fifo_sel_q  [AUX_DEPTH];
    logic [REG_DATA_WIDTH-1:0] fifo_data_q [AUX_DEPTH];
    logic [PW-1:0]             rd_ptr_q;
    logic [PW-1:0]             wr_ptr_q;
    logic [CW-1:0]             count_q;
    logic [CW-1:0]             count_d;
    logic                      rf_wen_q;
    logic [REG_SEL_BITS-1:0]   rf_sel_q;
    logic [REG_DATA_WIDTH-1:0] rf_data_q;
    logic                      init_done_q;

    logic in_run;
    logic aux_fire;
    logic push;
    logic wb_go;
    logic pop;

    assign in_run    = (state_q == S_RUN);
    // Ready comes from the registered count only, so a same-cycle pop
    // never opens a slot for a same-cycle push.
    assign aux_ready = in_run && (count_q < CW'(AUX_DEPTH));
    assign aux_fire  = aux_valid && aux_ready;
    // r0 is hardwired: a zero-select aux request completes its handshake
    // but is dropped; a zero-select writeback is treated as no request.
    assign push      = aux_fire && (aux_sel != '0);
    assign wb_go     = in_run && wb_valid && (wb_sel != '0);
    assign pop       = in_run && !wb_go && (count_q != '0);
    assign count_d   = count_q + CW'(push) - CW'(pop);

    // FIFO storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_sel_q[wr_ptr_q]  <= aux_sel;
            fifo_data_q[wr_ptr_q] <= aux_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_INIT;
            init_ptr_q  <= REG_SEL_BITS'(1);
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rf_wen_q    <= 1'b0;
            rf_sel_q    <= '0;
            rf_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    rf_wen_q   <= 1'b1;
                    rf_sel_q   <= init_ptr_q;
                    rf_data_q  <= '0;
                    init_ptr_q <= init_ptr_q + REG_SEL_BITS'(1);
                    if (init_ptr_q == '1) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (wb_go) begin
                        rf_wen_q  <= 1'b1;
                        rf_sel_q  <= wb_sel;
                        rf_data_q <= wb_data;
                    end else if (pop) begin
                        rf_wen_q  <= 1'b1;
                        rf_sel_q  <= fifo_sel_q[rd_ptr_q];
                        rf_data_q <= fifo_data_q[rd_ptr_q];
                    end else begin
                        // Select and data hold so the bus stays quiet when idle.
                        rf_wen_q  <= 1'b0;
                    end
                    if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                    if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                    count_q <= count_d;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    // Scan only the occupied slots, walking forward from the head. The
    // write currently on rf_* is included because the register file still
    // returns the old value during that cycle.
    always_comb begin
        chk_pending = rf_wen_q && (rf_sel_q == chk_sel);
        for (int k = 0; k < AUX_DEPTH; k++) begin
            if ((CW'(k) < count_q) && (fifo_sel_q[rd_ptr_q + PW'(k)] == chk_sel)) begin
                chk_pending = 1'b1;
            end
        end
        if (chk_sel == '0) chk_pending = 1'b0;
    end

    assign rf_wEn        = rf_wen_q;
    assign rf_write_sel  = rf_sel_q;
    assign rf_write_data = rf_data_q;
    assign init_done     = init_done_q;
    assign aux_count     = count_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Purpose: directed bench with a write scoreboard for regfile_write_scheduler.
// Latency: expected writes are queued at issue and matched one cycle later on rf_*.
// Backpressure: aux stalls are exercised by holding writeback while the FIFO fills.
module tb_regfile_write_scheduler;

    localparam int DW = 32;
    localparam int SW = 5;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic [SW-1:0] wb_sel;
    logic [DW-1:0] wb_data;
    logic          aux_valid;
    logic          aux_ready;
    logic [SW-1:0] aux_sel;
    logic [DW-1:0] aux_data;
    logic          rf_wEn;
    logic [SW-1:0] rf_write_sel;
    logic [DW-1:0] rf_write_data;
    logic [SW-1:0] chk_sel;
    logic          chk_pending;
    logic          init_done;
    logic [1:0]    aux_count;

    always #5 clock = ~clock;

    regfile_write_scheduler #(
        .REG_DATA_WIDTH(DW),
        .REG_SEL_BITS  (SW),
        .AUX_DEPTH     (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_sel       (wb_sel),
        .wb_data      (wb_data),
        .aux_valid    (aux_valid),
        .aux_ready    (aux_ready),
        .aux_sel      (aux_sel),
        .aux_data     (aux_data),
        .rf_wEn       (rf_wEn),
        .rf_write_sel (rf_write_sel),
        .rf_write_data(rf_write_data),
        .chk_sel      (chk_sel),
        .chk_pending  (chk_pending),
        .init_done    (init_done),
        .aux_count    (aux_count)
    );

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic expect_wr(input logic [SW-1:0] s, input logic [DW-1:0] d);
        exp_q.push_back({s, d});
    endtask

    task automatic expect_init();
        for (int i = 1; i < 32; i++) expect_wr(SW'(i), '0);
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    task automatic probe(input logic [SW-1:0] s, input logic req, input string name);
        chk_sel = s;
        #1;
        check(name, 64'(chk_pending), 64'(req));
    endtask

    // Monitor: every write presented on rf_* must match the scoreboard head.
    always @(negedge clock) begin
        if (rf_wEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got sel %0d data 0x%0h, required no write",
                         rf_write_sel, rf_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rf_write_sel", 64'(rf_write_sel), 64'(mon_e.sel));
                check("rf_write_data", 64'(rf_write_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; wb_valid = 1'b0; wb_sel = '0; wb_data = '0;
        aux_valid = 1'b0; aux_sel = '0; aux_data = '0; chk_sel = '0;

        // 1: reset state, then the 31-cycle clear sweep
        nxt(); nxt();
        check("rst_wen", 64'(rf_wEn), 0);
        check("rst_sel", 64'(rf_write_sel), 0);
        check("rst_data", 64'(rf_write_data), 0);
        check("rst_init_done", 64'(init_done), 0);
        check("rst_aux_ready", 64'(aux_ready), 0);
        check("rst_aux_count", 64'(aux_count), 0);
        reset = 1'b1;
        expect_init();
        for (int i = 1; i <= 31; i++) begin
            nxt();
            check("init_wen", 64'(rf_wEn), 1);
            if (i < 31) check("init_done_low", 64'(init_done), 0);
        end
        nxt();
        check("idle_wen", 64'(rf_wEn), 0);
        check("idle_init_done", 64'(init_done), 1);
        check("idle_aux_ready", 64'(aux_ready), 1);
        check("idle_aux_count", 64'(aux_count), 0);

        // 2: single writeback and its pending window
        wb_valid = 1'b1; wb_sel = 5'd5; wb_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        nxt();
        wb_valid = 1'b0;
        probe(5'd5, 1'b1, "t2_pending_inflight");
        nxt();
        probe(5'd5, 1'b0, "t2_pending_cleared");
        check("t2_wen_off", 64'(rf_wEn), 0);

        // 3: writeback stream blocks aux drain until the FIFO fills
        wb_valid = 1'b1; wb_sel = 5'd3; wb_data = 32'h33;
        aux_valid = 1'b1; aux_sel = 5'd7; aux_data = 32'h11;
        check("t3_ready_empty", 64'(aux_ready), 1);
        expect_wr(5'd3, 32'h33);
        nxt();
        check("t3_count1", 64'(aux_count), 1);
        aux_sel = 5'd9; aux_data = 32'h22;
        expect_wr(5'd3, 32'h33);
        nxt();
        check("t3_count2", 64'(aux_count), 2);
        check("t3_ready_full", 64'(aux_ready), 0);
        probe(5'd7, 1'b1, "t3_pending_7");
        probe(5'd9, 1'b1, "t3_pending_9");
        aux_sel = 5'd12; aux_data = 32'h44;
        expect_wr(5'd3, 32'h33);
        nxt();
        check("t3_stalled_ready", 64'(aux_ready), 0);
        check("t3_stalled_count", 64'(aux_count), 2);
        wb_valid = 1'b0;
        expect_wr(5'd7, 32'h11);
        expect_wr(5'd9, 32'h22);
        expect_wr(5'd12, 32'h44);
        nxt();
        check("t3_ready_after_pop", 64'(aux_ready), 1);
        check("t3_count_after_pop", 64'(aux_count), 1);
        nxt();
        aux_valid = 1'b0;
        check("t3_push_pop_count", 64'(aux_count), 1);
        probe(5'd12, 1'b1, "t3_pending_12");
        nxt();
        check("t3_drained", 64'(aux_count), 0);

        // 4: same-register wb and aux in one cycle; aux lands last
        wb_valid = 1'b1; wb_sel = 5'd4; wb_data = 32'hA;
        aux_valid = 1'b1; aux_sel = 5'd4; aux_data = 32'hB;
        expect_wr(5'd4, 32'hA);
        expect_wr(5'd4, 32'hB);
        nxt();
        wb_valid = 1'b0; aux_valid = 1'b0;
        check("t4_count1", 64'(aux_count), 1);
        nxt();
        probe(5'd4, 1'b1, "t4_pending_4");
        check("t4_count0", 64'(aux_count), 0);
        nxt();
        check("t4_wen_off", 64'(rf_wEn), 0);
        probe(5'd4, 1'b0, "t4_pending_clear");

        // 5: zero-register requests
        wb_valid = 1'b1; wb_sel = 5'd0; wb_data = 32'h55;
        aux_valid = 1'b1; aux_sel = 5'd0; aux_data = 32'h66;
        check("t5_ready_zero", 64'(aux_ready), 1);
        nxt();
        check("t5_count_zero", 64'(aux_count), 0);
        check("t5_no_write", 64'(rf_wEn), 0);
        wb_valid = 1'b0;
        aux_sel = 5'd6; aux_data = 32'h77;
        nxt();
        check("t5_queued", 64'(aux_count), 1);
        aux_valid = 1'b0;
        wb_valid = 1'b1; wb_sel = 5'd0;
        expect_wr(5'd6, 32'h77);
        nxt();
        check("t5_drain_count", 64'(aux_count), 0);
        check("t5_drain_wen", 64'(rf_wEn), 1);

        // 6: reset with two queued entries; they must never be written
        wb_valid = 1'b1; wb_sel = 5'd3; wb_data = 32'h99;
        aux_valid = 1'b1; aux_sel = 5'd20; aux_data = 32'hE1;
        expect_wr(5'd3, 32'h99);
        nxt();
        aux_sel = 5'd21; aux_data = 32'hE2;
        expect_wr(5'd3, 32'h99);
        nxt();
        check("t6_count_full", 64'(aux_count), 2);
        reset = 1'b0; wb_valid = 1'b0; aux_valid = 1'b0;
        nxt();
        check("t6_rst_count", 64'(aux_count), 0);
        check("t6_rst_init_done", 64'(init_done), 0);
        check("t6_rst_ready", 64'(aux_ready), 0);
        check("t6_rst_wen", 64'(rf_wEn), 0);
        reset = 1'b1;
        expect_init();
        for (int i = 1; i <= 31; i++) nxt();
        nxt();
        check("t6_init_done", 64'(init_done), 1);
        check("t6_idle_wen", 64'(rf_wEn), 0);
        check("t6_idle_count", 64'(aux_count), 0);
        nxt();
        check("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
